// File: rtl/mem_access_unit_pkg.sv
// Shared types and op decode helpers for the MEM stage and its data bus.
// Combinational helpers only: no latency, no backpressure.
// Bus structs are sized for the widest datapath (64 bits, 8 lanes).
package mem_access_unit_pkg;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_LB,
        OP_LH,
        OP_LW,
        OP_LD,
        OP_LBU,
        OP_LHU,
        OP_LWU,
        OP_SB,
        OP_SH,
        OP_SW,
        OP_SD
    } mem_op_t;

    typedef enum logic [1:0] {
        MSIZE_B,
        MSIZE_H,
        MSIZE_W,
        MSIZE_D
    } msize_t;

    localparam int BUS_W     = 64;
    localparam int BUS_LANES = BUS_W / 8;

    typedef struct packed {
        logic                 valid;
        logic [BUS_W-1:0]     addr;
        msize_t               size;
        logic [BUS_LANES-1:0] strobe;
        logic [BUS_W-1:0]     data;
    } dbus_req_t;

    typedef struct packed {
        logic             addr_ok;
        logic             data_ok;
        logic [BUS_W-1:0] data;
    } dbus_resp_t;

    function automatic logic is_load(mem_op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    function automatic logic op_signed(mem_op_t op);
        return op inside {OP_LB, OP_LH, OP_LW};
    endfunction

    function automatic logic [3:0] op_bytes(mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'd1;
            OP_LH, OP_LHU, OP_SH: return 4'd2;
            OP_LW, OP_LWU, OP_SW: return 4'd4;
            OP_LD, OP_SD:         return 4'd8;
            default:              return 4'd0;
        endcase
    endfunction

    function automatic msize_t op_size(mem_op_t op);
        case (op_bytes(op))
            4'd2:    return MSIZE_H;
            4'd4:    return MSIZE_W;
            4'd8:    return MSIZE_D;
            default: return MSIZE_B;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Lane alignment: store strobes, shifted write data, extended load data, misalignment.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are used.
module mem_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int LANES = XLEN / 8,
    localparam int OFF_W = $clog2(LANES)
) (
    input  mem_op_t          op,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output logic [LANES-1:0] strobe,
    output logic [XLEN-1:0]  wdataShifted,
    output logic [XLEN-1:0]  rdataExt,
    output logic             misaligned
);

    logic [3:0]  bytes;
    logic [7:0]  alignMask;
    logic [15:0] strobeBase;
    logic [15:0] strobeWide;
    logic [63:0] rdShift;
    logic [63:0] rdExt64;
    logic        sgn;

    always_comb begin
        bytes      = op_bytes(op);
        alignMask  = {4'b0000, bytes} - 8'd1;
        strobeBase = (16'd1 << bytes) - 16'd1;
        strobeWide = strobeBase << offset;
        strobe     = is_store(op) ? strobeWide[LANES-1:0] : '0;
        misaligned = (is_load(op) || is_store(op)) && ((8'(offset) & alignMask) != 8'd0);

        wdataShifted = wdata << {offset, 3'b000};

        // Extension is done at 64 bits so the 32-bit datapath needs no special case.
        rdShift = 64'(rdata >> {offset, 3'b000});
        sgn     = op_signed(op);
        case (bytes)
            4'd1:    rdExt64 = {{56{sgn & rdShift[7]}}, rdShift[7:0]};
            4'd2:    rdExt64 = {{48{sgn & rdShift[15]}}, rdShift[15:0]};
            4'd4:    rdExt64 = {{32{sgn & rdShift[31]}}, rdShift[31:0]};
            default: rdExt64 = rdShift;
        endcase
        rdataExt = rdExt64[XLEN-1:0];
    end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked MEM stage: one op at a time through IDLE -> WAIT (bus access) -> DONE.
// Latency: 1 cycle for NONE/misaligned, >= 2 cycles for bus ops (until data_ok).
// Backpressure: in_ready only in IDLE; DONE holds all results until out_ready.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  mem_op_t         in_op,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_wa,
    input  logic            in_regwrite,
    input  logic [XLEN-1:0] in_pc,
    output dbus_req_t       dreq,
    input  dbus_resp_t      dresp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_wa,
    output logic            out_regwrite,
    output logic [XLEN-1:0] out_pc,
    output logic            misalign,
    output logic [4:0]      fwd_wa,
    output logic            fwd_regwrite,
    output logic            fwd_valid,
    output logic [XLEN-1:0] fwd_result
);

    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state;
    mem_op_t    opReg;
    mem_op_t    inOpEff;
    mem_op_t    alignOp;
    logic [XLEN-1:0]  addrReg;
    logic [OFF_W-1:0] alignOff;
    logic [LANES-1:0] alignStrobe;
    logic [XLEN-1:0]  alignWdata;
    logic [XLEN-1:0]  alignRdata;
    logic             alignMis;
    logic             memOp;
    logic             trapMis;
    logic             unusedBits;

    // Doubleword ops do not exist on a 32-bit datapath and degrade to NONE.
    always_comb begin
        inOpEff = in_op;
        if (XLEN == 32 && (in_op == OP_LD || in_op == OP_SD)) begin
            inOpEff = OP_NONE;
        end
    end

    assign alignOp  = (state == S_IDLE) ? inOpEff : opReg;
    assign alignOff = (state == S_IDLE) ? in_addr[OFF_W-1:0] : addrReg[OFF_W-1:0];
    assign memOp    = is_load(inOpEff) || is_store(inOpEff);
    assign trapMis  = ALIGN_CHECK && alignMis;
    assign unusedBits = dresp.addr_ok;

    mem_align #(.XLEN(XLEN)) u_align (
        .op           (alignOp),
        .offset       (alignOff),
        .wdata        (in_wdata),
        .rdata        (dresp.data[XLEN-1:0]),
        .strobe       (alignStrobe),
        .wdataShifted (alignWdata),
        .rdataExt     (alignRdata),
        .misaligned   (alignMis)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            dreq         <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_wa       <= '0;
            out_regwrite <= 1'b0;
            out_pc       <= '0;
            misalign     <= 1'b0;
            fwd_valid    <= 1'b0;
            opReg        <= OP_NONE;
            addrReg      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready     <= 1'b0;
                        opReg        <= inOpEff;
                        addrReg      <= in_addr;
                        out_wa       <= in_wa;
                        out_pc       <= in_pc;
                        out_result   <= in_addr;
                        out_regwrite <= in_regwrite & ~(memOp & trapMis);
                        if (memOp && !trapMis) begin
                            state       <= S_WAIT;
                            dreq.valid  <= 1'b1;
                            dreq.addr   <= BUS_W'(in_addr);
                            dreq.size   <= op_size(inOpEff);
                            dreq.strobe <= BUS_LANES'(alignStrobe);
                            dreq.data   <= is_store(inOpEff) ? BUS_W'(alignWdata) : '0;
                            // A store's result (its address) is final before the bus completes.
                            fwd_valid   <= is_store(inOpEff);
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            misalign  <= memOp & trapMis;
                            fwd_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (dresp.data_ok) begin
                        state       <= S_DONE;
                        dreq        <= '0;
                        out_valid   <= 1'b1;
                        fwd_valid   <= 1'b1;
                        if (is_load(opReg)) begin
                            out_result <= alignRdata;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        misalign  <= 1'b0;
                        fwd_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fwd_wa       = out_wa;
    assign fwd_regwrite = out_regwrite;
    assign fwd_result   = fwd_valid ? out_result : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=64, ALIGN_CHECK=1).
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    mem_op_t     in_op;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_wa;
    logic        in_regwrite;
    logic [63:0] in_pc;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_wa;
    logic        out_regwrite;
    logic [63:0] out_pc;
    logic        misalign;
    logic [4:0]  fwd_wa;
    logic        fwd_regwrite;
    logic        fwd_valid;
    logic [63:0] fwd_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(64), .ALIGN_CHECK(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_wa        (in_wa),
        .in_regwrite  (in_regwrite),
        .in_pc        (in_pc),
        .dreq         (dreq),
        .dresp        (dresp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_wa       (out_wa),
        .out_regwrite (out_regwrite),
        .out_pc       (out_pc),
        .misalign     (misalign),
        .fwd_wa       (fwd_wa),
        .fwd_regwrite (fwd_regwrite),
        .fwd_valid    (fwd_valid),
        .fwd_result   (fwd_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic doLoad(input string tag, input mem_op_t op, input logic [63:0] addr,
                          input logic [63:0] rd, input logic [63:0] exp);
        in_valid = 1'b1; in_op = op; in_addr = addr;
        in_wa = 5'd7; in_regwrite = 1'b1; in_pc = 64'h100;
        tick();
        in_valid = 1'b0;
        chk({tag, "_req_vld"}, 64'(dreq.valid), 64'd1);
        chk({tag, "_strobe0"}, 64'(dreq.strobe), 64'd0);
        chk({tag, "_fwd_pend"}, 64'(fwd_valid), 64'd0);
        chk({tag, "_fwd_wa"}, 64'(fwd_wa), 64'd7);
        tick();
        chk({tag, "_still_wait"}, 64'(out_valid), 64'd0);
        chk({tag, "_fwd_res0"}, fwd_result, 64'd0);
        dresp.data_ok = 1'b1; dresp.data = rd;
        tick();
        dresp.data_ok = 1'b0; dresp.data = '0;
        chk({tag, "_out_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_result"}, out_result, exp);
        chk({tag, "_fwd_vld"}, 64'(fwd_valid), 64'd1);
        chk({tag, "_fwd_res"}, fwd_result, exp);
        chk({tag, "_req_drop"}, 64'(dreq.valid), 64'd0);
        chk({tag, "_pc"}, out_pc, 64'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = OP_NONE; in_addr = '0; in_wdata = '0;
        in_wa = '0; in_regwrite = 1'b0; in_pc = '0; dresp = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_req_vld", 64'(dreq.valid), 64'd0);
        chk("rst_strobe", 64'(dreq.strobe), 64'd0);
        chk("rst_out_vld", 64'(out_valid), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        chk("rst_fwd_vld", 64'(fwd_valid), 64'd0);
        chk("rst_result", out_result, 64'd0);
        reset = 1'b0;
        tick();

        // SW to upper word: strobe F0, data in [63:32], three wait cycles.
        in_valid = 1'b1; in_op = OP_SW; in_addr = 64'h1004; in_wdata = 64'hDEADBEEF;
        in_wa = 5'd0; in_regwrite = 1'b0; in_pc = 64'h80;
        tick();
        in_valid = 1'b0;
        chk("sw_in_ready", 64'(in_ready), 64'd0);
        chk("sw_strobe", 64'(dreq.strobe), 64'hF0);
        chk("sw_data_hi", 64'(dreq.data[63:32]), 64'hDEADBEEF);
        chk("sw_data", dreq.data, 64'hDEADBEEF_0000_0000);
        chk("sw_size", 64'(dreq.size), 64'd2);
        chk("sw_addr", dreq.addr, 64'h1004);
        chk("sw_fwd_wait", 64'(fwd_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_hold_vld", 64'(dreq.valid), 64'd1);
            chk("sw_hold_strobe", 64'(dreq.strobe), 64'hF0);
            chk("sw_hold_out", 64'(out_valid), 64'd0);
        end
        dresp.data_ok = 1'b1;
        tick();
        dresp.data_ok = 1'b0;
        chk("sw_done_vld", 64'(out_valid), 64'd1);
        chk("sw_done_res", out_result, 64'h1004);
        chk("sw_done_req", 64'(dreq.valid), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // SB to the top lane.
        in_valid = 1'b1; in_op = OP_SB; in_addr = 64'h1007; in_wdata = 64'hAB;
        tick();
        in_valid = 1'b0;
        chk("sb_strobe", 64'(dreq.strobe), 64'h80);
        chk("sb_data", dreq.data, 64'hAB00_0000_0000_0000);
        chk("sb_size", 64'(dreq.size), 64'd0);
        dresp.data_ok = 1'b1;
        tick();
        dresp.data_ok = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        doLoad("lb",  OP_LB,  64'h2003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        doLoad("lbu", OP_LBU, 64'h2003, 64'h0000_0000_8000_0000, 64'h80);
        doLoad("lh",  OP_LH,  64'h2006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        doLoad("lwu", OP_LWU, 64'h2004, 64'hF000_0000_0000_0000, 64'hF000_0000);
        doLoad("ld",  OP_LD,  64'h5000, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);

        // Misaligned LH: no bus request, result next cycle, then 4 cycles of backpressure.
        in_valid = 1'b1; in_op = OP_LH; in_addr = 64'h2001; in_wa = 5'd9; in_regwrite = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mis_req", 64'(dreq.valid), 64'd0);
        chk("mis_out_vld", 64'(out_valid), 64'd1);
        chk("mis_flag", 64'(misalign), 64'd1);
        chk("mis_regwrite", 64'(out_regwrite), 64'd0);
        chk("mis_result", out_result, 64'h2001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_out_vld", 64'(out_valid), 64'd1);
            chk("bp_result", out_result, 64'h2001);
            chk("bp_wa", 64'(out_wa), 64'd9);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_req", 64'(dreq.valid), 64'd0);
        end

        // Release with a NONE op already waiting: accepted one cycle after IDLE.
        out_ready = 1'b1; in_valid = 1'b1; in_op = OP_NONE; in_addr = 64'h3000; in_regwrite = 1'b1;
        tick();
        chk("rel_out_vld", 64'(out_valid), 64'd0);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_misalign", 64'(misalign), 64'd0);
        tick();
        chk("none0_vld", 64'(out_valid), 64'd1);
        chk("none0_res", out_result, 64'h3000);
        chk("none0_fwd", 64'(fwd_valid), 64'd1);
        chk("none0_rw", 64'(out_regwrite), 64'd1);
        for (int i = 1; i < 4; i++) begin
            in_addr = 64'h3000 + 64'(i * 8);
            tick();
            chk("none_gap", 64'(out_valid), 64'd0);
            tick();
            chk("none_vld", 64'(out_valid), 64'd1);
            chk("none_res", out_result, 64'h3000 + 64'(i * 8));
            chk("none_fwd_res", fwd_result, 64'h3000 + 64'(i * 8));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a load.
        in_valid = 1'b1; in_op = OP_LW; in_addr = 64'h4000;
        tick();
        in_valid = 1'b0;
        chk("ar_wait_req", 64'(dreq.valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req", 64'(dreq.valid), 64'd0);
        chk("ar_out_vld", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        #2 reset = 1'b0;
        tick(); tick();
        chk("ar_post_vld", 64'(out_valid), 64'd0);
        chk("ar_post_rdy", 64'(in_ready), 64'd1);
        chk("ar_post_req", 64'(dreq.valid), 64'd0);
        chk("ar_post_res", out_result, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
